// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// counter sizing and the add/sub slice used by the trial subtractor.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Step counter only has to reach WIDTH-1.
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // One add/sub slice: mode=1 inverts b so that a chain with carry-in 1 subtracts.
    function automatic logic slice_sum(input logic a, input logic b, input logic cin,
                                       input logic mode);
        logic bx;
        bx = b ^ mode;
        return a ^ bx ^ cin;
    endfunction

    function automatic logic slice_carry(input logic a, input logic b, input logic cin,
                                         input logic mode);
        logic bx;
        bx = b ^ mode;
        return (a & bx) | (cin & (a ^ bx));
    endfunction

endpackage

// File: rtl/seq_restoring_divider_sub_ripple.sv
// Ripple subtractor a - b over zero-extended WIDTH+1-bit operands; borrow is
// the inverted carry-out of the extra top slice.
module sub_ripple
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic cy;

    always_comb begin
        diff = '0;
        cy   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = slice_sum(a[i], b[i], cy, 1'b1);
            cy      = slice_carry(a[i], b[i], cy, 1'b1);
        end
        // Zero-extension slice: only its carry matters.
        cy     = slice_carry(1'b0, 1'b0, cy, 1'b1);
        borrow = ~cy;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional: DIV_ZERO_FAST_EN sends a zero-divisor request straight to DONE.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_run_q, dz_run_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] r_shift, t_diff;
    logic             t_borrow, accept, zero_div;

    assign accept   = (state_q == S_IDLE) && start;
    assign zero_div = (divisor == '0);
    assign r_shift  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    sub_ripple #(.WIDTH(WIDTH)) u_sub (
        .a      (r_shift),
        .b      (d_q),
        .diff   (t_diff),
        .borrow (t_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            dz_run_q <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            dz_run_q <= dz_run_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = zero_div ? S_DONE : S_RUN;
`else
                    state_d = S_RUN;
`endif
                end
            end
            S_RUN:   if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: results are only published on the transition into DONE.
    always_comb begin
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        dz_run_d = dz_run_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        if (accept) begin
            r_d      = '0;
            q_d      = dividend;
            d_d      = divisor;
            cnt_d    = '0;
            dz_run_d = zero_div;
`ifdef DIV_ZERO_FAST_EN
            if (zero_div) begin
                quot_d = '1;
                rem_d  = dividend;
                dbz_d  = 1'b1;
            end
`endif
        end else if (state_q == S_RUN) begin
            r_d   = t_borrow ? r_shift : t_diff;
            q_d   = {q_q[WIDTH-2:0], ~t_borrow};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
                quot_d = q_d;
                rem_d  = r_d;
                dbz_d  = dz_run_q;
            end
        end
    end

    always_comb begin
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8) against a plain
// arithmetic reference; honours DIV_ZERO_FAST_EN for zero-divisor latency.
module tb_seq_restoring_divider;

    localparam int W = 8;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output int exp_busy, output int exp_wait);
        if (b == 0) begin
            q        = {W{1'b1}};
            r        = a;
            exp_busy = FAST ? 0 : W;
            exp_wait = FAST ? 1 : W + 1;
        end else begin
            q        = a / b;
            r        = a % b;
            exp_busy = W;
            exp_wait = W + 1;
        end
    endfunction

    // Driver: one request from IDLE, observe until done (bounded), then one more cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int busy_cnt, output int done_wait,
                          output bit timed_out, output bit overlap, output logic wide_done);
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        busy_cnt = 0; done_wait = 0; timed_out = 1'b1; overlap = 1'b0;
        q = '0; r = '0; dz = 1'b0; wide_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (busy && done) overlap = 1'b1;
            if (busy) busy_cnt++;
            if (done) begin
                done_wait = i; q = quotient; r = remainder; dz = div_by_zero;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        if (!timed_out) begin
            @(posedge clk); #1;
            wide_done = done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0
            || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [W-1:0] q, r, eq, er;
        logic dz, wd;
        int bc, dw, eb, ew;
        bit to, ov;
        model(a, b, eq, er, eb, ew);
        run_op(a, b, q, r, dz, bc, dw, to, ov, wd);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
        end
        checks++;
        if (q !== eq || r !== er || dz !== (b == 0)) begin
            failures++;
            $display("FAIL %s_result: q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                     name, q, r, dz, eq, er, (b == 0));
        end
        checks++;
        if (bc !== eb || dw !== ew) begin
            failures++;
            $display("FAIL %s_latency: busy_cycles=%0d done_at=%0d want %0d %0d",
                     name, bc, dw, eb, ew);
        end
        checks++;
        if (ov || wd !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse: overlap=%b done_2nd_cycle=%b want 0 0", name, ov, wd);
        end
    endtask

    task automatic test_back_to_back();
        int n_done, last, gap;
        n_done = 0; last = 0;
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd200; divisor = 8'd10;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                gap = (n_done == 0) ? W + 1 : W + 2;
                checks++;
                if ((i - last) !== gap || quotient !== 8'd20 || remainder !== 8'd0 || busy) begin
                    failures++;
                    $display("FAIL b2b_op%0d: gap=%0d q=%0d r=%0d busy=%b want gap=%0d q=20 r=0 busy=0",
                             n_done, i - last, quotient, remainder, busy, gap);
                end
                last = i;
                n_done++;
            end
        end
        start = 1'b0;
        checks++;
        if (n_done !== 3) begin
            failures++;
            $display("FAIL b2b_count: done_pulses=%0d want 3", n_done);
        end
        // Second start mid-RUN with different operands must be ignored.
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd200; divisor = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        last = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin last = i; break; end
            if (i == 3) begin start = 1'b1; dividend = 8'd3; divisor = 8'd3; end
            if (i == 4) start = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (last !== W + 1 || quotient !== 8'd20 || remainder !== 8'd0) begin
            failures++;
            $display("FAIL midrun_start: done_at=%0d q=%0d r=%0d want %0d 20 0",
                     last, quotient, remainder, W + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0
            || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        #2 rst_n = 1'b1;
        test_directed(8'd9, 8'd2, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic dz, wd;
        int bc, dw, eb, ew, hold;
        bit to, ov, stable;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0
              : ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 255));
            model(a, b, eq, er, eb, ew);
            run_op(a, b, q, r, dz, bc, dw, to, ov, wd);
            checks++;
            if (to || q !== eq || r !== er || dz !== (b == 0)) begin
                failures++;
                $display("FAIL rand_result: %0d/%0d timeout=%b q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                         a, b, to, q, r, dz, eq, er, (b == 0));
            end
            checks++;
            if (bc !== eb || dw !== ew || ov || wd !== 1'b0) begin
                failures++;
                $display("FAIL rand_timing: %0d/%0d busy=%0d done_at=%0d overlap=%b wide=%b want %0d %0d 0 0",
                         a, b, bc, dw, ov, wd, eb, ew);
            end
            hold = $urandom_range(0, 3);
            stable = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                if (quotient !== eq || remainder !== er || div_by_zero !== (b == 0) || done)
                    stable = 1'b0;
            end
            checks++;
            if (!stable) begin
                failures++;
                $display("FAIL rand_hold: %0d/%0d q=%0d r=%0d done=%b want q=%0d r=%0d held",
                         a, b, quotient, remainder, done, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed(8'd100, 8'd7, "div_100_7");
        test_directed(8'd5, 8'd9, "div_5_9");
        test_directed(8'd255, 8'd1, "div_255_1");
        test_directed(8'd77, 8'd0, "div_77_0");
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
